// File: rtl/mem_access_stage.sv
// Memory-access stage: registers ALU results, resolves CBZ, runs data-cache
// loads/stores over a req/ack handshake and emits a one-cycle write-back packet.
module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        exValid,
    input  logic [31:0] aluResult,
    input  logic [31:0] storeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        branch,
    input  logic [4:0]  destReg,
    input  logic [31:0] branchTarget,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        wbValid,
    output logic [31:0] wbData,
    output logic [4:0]  wbReg,
    output logic        wbRegWrite,
    output logic        branchTaken,
    output logic [31:0] branchPc,
    output logic        memError
);

    typedef enum logic {IDLE, WAIT_ACK} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(ACK_TIMEOUT - 1);
    localparam logic [4:0] XZR        = 5'd31;

    state_t      state, state_nx;
    logic [7:0]  count, count_nx;
    logic [4:0]  lat_reg, lat_reg_nx;
    logic        lat_rw, lat_rw_nx;
    logic        stall_nx, mem_req_nx, mem_we_nx, mem_error_nx;
    logic [31:0] mem_addr_nx, mem_wdata_nx;
    logic        wb_valid_nx, wb_rw_nx, br_taken_nx;
    logic [31:0] wb_data_nx, br_pc_nx;
    logic [4:0]  wb_reg_nx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            lat_reg     <= '0;
            lat_rw      <= 1'b0;
            stall       <= 1'b0;
            memReq      <= 1'b0;
            memWe       <= 1'b0;
            memAddr     <= '0;
            memWData    <= '0;
            wbValid     <= 1'b0;
            wbData      <= '0;
            wbReg       <= '0;
            wbRegWrite  <= 1'b0;
            branchTaken <= 1'b0;
            branchPc    <= '0;
            memError    <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            lat_reg     <= lat_reg_nx;
            lat_rw      <= lat_rw_nx;
            stall       <= stall_nx;
            memReq      <= mem_req_nx;
            memWe       <= mem_we_nx;
            memAddr     <= mem_addr_nx;
            memWData    <= mem_wdata_nx;
            wbValid     <= wb_valid_nx;
            wbData      <= wb_data_nx;
            wbReg       <= wb_reg_nx;
            wbRegWrite  <= wb_rw_nx;
            branchTaken <= br_taken_nx;
            branchPc    <= br_pc_nx;
            memError    <= mem_error_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        count_nx     = count;
        lat_reg_nx   = lat_reg;
        lat_rw_nx    = lat_rw;
        stall_nx     = stall;
        mem_req_nx   = memReq;
        mem_we_nx    = memWe;
        mem_addr_nx  = memAddr;
        mem_wdata_nx = memWData;
        wb_valid_nx  = 1'b0;
        wb_data_nx   = wbData;
        wb_reg_nx    = wbReg;
        wb_rw_nx     = wbRegWrite;
        br_taken_nx  = 1'b0;
        br_pc_nx     = branchPc;
        mem_error_nx = memError;

        unique case (state)
            IDLE: begin
                if (exValid) begin
                    if (branch) begin
                        br_taken_nx = aluResult[0];
                        br_pc_nx    = branchTarget;
                        wb_valid_nx = 1'b1;
                        wb_data_nx  = aluResult;
                        wb_reg_nx   = destReg;
                        wb_rw_nx    = 1'b0;
                    end else if (memRead || memWrite) begin
                        mem_req_nx   = 1'b1;
                        mem_we_nx    = memWrite;
                        mem_addr_nx  = aluResult;
                        mem_wdata_nx = storeData;
                        lat_reg_nx   = destReg;
                        lat_rw_nx    = regWrite;
                        stall_nx     = 1'b1;
                        count_nx     = '0;
                        state_nx     = WAIT_ACK;
                    end else begin
                        wb_valid_nx = 1'b1;
                        wb_data_nx  = aluResult;
                        wb_reg_nx   = destReg;
                        wb_rw_nx    = regWrite && (destReg != XZR);
                    end
                end
            end
            WAIT_ACK: begin
                // An ack on the final timeout cycle still completes normally.
                if (memAck) begin
                    mem_req_nx  = 1'b0;
                    stall_nx    = 1'b0;
                    wb_valid_nx = 1'b1;
                    wb_reg_nx   = lat_reg;
                    state_nx    = IDLE;
                    if (memWe) begin
                        wb_data_nx = '0;
                        wb_rw_nx   = 1'b0;
                    end else begin
                        wb_data_nx = memRData;
                        wb_rw_nx   = lat_rw && (lat_reg != XZR);
                    end
                end else if (count == LAST_COUNT) begin
                    mem_req_nx   = 1'b0;
                    stall_nx     = 1'b0;
                    mem_error_nx = 1'b1;
                    wb_valid_nx  = 1'b1;
                    wb_data_nx   = '0;
                    wb_reg_nx    = lat_reg;
                    wb_rw_nx     = 1'b0;
                    state_nx     = IDLE;
                end else begin
                    count_nx = count + 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
